// File: rtl/seg7_scan_n.sv
// seg7_scan_n: N-digit multiplexed 7-segment scanner.
// One digit is driven per slot of DIV clocks. A full frame is sampled into
// shadow registers at the frame boundary so the display never tears, then
// decoded with leading-zero blanking, per-digit decimal point and blink.
// seg/an are registered; pin polarity is applied after the registers so that
// reset drives the inactive level without waiting for a clock edge.
module seg7_scan_n #(
    parameter int DIGITS      = 4,
    parameter int DIV         = 1000,
    parameter int BLINK_TICKS = 256,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   di,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lzb,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0]         pre_q;
    logic [DW-1:0]         dig_q;
    logic [BW-1:0]         blk_cnt_q;
    logic                  blk_ph_q;
    logic                  first_q;
    logic [4*DIGITS-1:0]   sh_di;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blink;
    logic                  sh_lzb;
    logic [7:0]            seg_q;
    logic [DIGITS-1:0]     an_q;
    logic                  frame_q;

    logic                  tick;
    logic                  last_dig;
    logic                  load;
    logic [DIGITS-1:0]     lz_mask;
    logic                  zero_run;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  bl_bit;
    logic                  blank_bit;
    logic [6:0]            seg7;
    logic [7:0]            seg_d;
    logic [DIGITS-1:0]     an_d;

    assign tick     = (pre_q == PW'(DIV - 1));
    assign last_dig = (dig_q == DW'(DIGITS - 1));
    // Load once right after reset, then at every wrap back to digit 0.
    assign load     = first_q | (tick & last_dig);

    // Prescaler: free-running 0..DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      pre_q <= '0;
        else if (tick)  pre_q <= '0;
        else            pre_q <= pre_q + PW'(1);
    end

    // Digit index: advances once per slot and wraps after the last digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          dig_q <= '0;
        else if (tick) begin
            if (last_dig)   dig_q <= '0;
            else            dig_q <= dig_q + DW'(1);
        end
    end

    // Blink timing: count slots, flip the phase every BLINK_TICKS slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt_q <= '0;
            blk_ph_q  <= 1'b0;
        end else if (tick) begin
            if (blk_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blk_cnt_q <= '0;
                blk_ph_q  <= ~blk_ph_q;
            end else begin
                blk_cnt_q <= blk_cnt_q + BW'(1);
            end
        end
    end

    // Shadow frame sample; frame marks the cycle the new sample is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_di    <= '0;
            sh_dp    <= '0;
            sh_blink <= '0;
            sh_lzb   <= 1'b0;
            first_q  <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            frame_q <= load;
            if (load) begin
                sh_di    <= di;
                sh_dp    <= dp;
                sh_blink <= blink_en;
                sh_lzb   <= lzb;
                first_q  <= 1'b0;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and all higher nibbles are 0.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (sh_di[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run & sh_lzb;
        end
    end

    // Pick the current digit's shadow fields and build the one-hot enable.
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        bl_bit    = 1'b0;
        blank_bit = 1'b0;
        an_d      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                nib       = sh_di[4*i +: 4];
                dp_bit    = sh_dp[i];
                bl_bit    = sh_blink[i];
                blank_bit = lz_mask[i];
                an_d[i]   = 1'b1;
            end
        end
    end

    // Hex to segments, active-high {g,f,e,d,c,b,a}.
    always_comb begin
        case (nib)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    end

    // Compose the next pin pattern; nothing is shown until the first sample exists.
    always_comb begin
        seg_d = {dp_bit, (blank_bit ? 7'h00 : seg7)};
        if (bl_bit && blk_ph_q) seg_d = 8'h00;
        if (first_q) begin
            seg_d = 8'h00;
        end
    end

    // Output registers, active-high internally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= 8'h00;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            an_q  <= first_q ? '0 : an_d;
        end
    end

    assign seg   = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
    assign an    = (AN_ACT_LOW != 0) ? ~an_q : an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Bench for seg7_scan_n: a 4-digit active-high instance (DIV=4, BLINK_TICKS=2)
// driven from a vector table and hand sequences, plus an 8-digit active-low
// instance (DIV=2). Expected pin values are pushed to exp_q when stimulus is
// applied and popped as the display reaches each digit slot.
module tb_seg7_scan_n;

    logic        clk;
    logic        reset;
    logic [15:0] di1;
    logic [3:0]  dp1, bl1;
    logic        lzb1;
    logic [7:0]  seg1;
    logic [3:0]  an1;
    logic        frame1;
    logic [31:0] di2;
    logic [7:0]  dp2, bl2;
    logic        lzb2;
    logic [7:0]  seg2;
    logic [7:0]  an2;
    logic        frame2;

    int checks = 0;
    int passes = 0;
    logic [15:0] exp_q[$];

    seg7_scan_n #(.DIGITS(4), .DIV(4), .BLINK_TICKS(2), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) u_dut1 (
        .clk(clk), .reset(reset), .di(di1), .dp(dp1), .blink_en(bl1), .lzb(lzb1),
        .seg(seg1), .an(an1), .frame(frame1)
    );

    seg7_scan_n #(.DIGITS(8), .DIV(2), .BLINK_TICKS(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) u_dut2 (
        .clk(clk), .reset(reset), .di(di2), .dp(dp2), .blink_en(bl2), .lzb(lzb2),
        .seg(seg2), .an(an2), .frame(frame2)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] di;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lzb;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0} active-high seg
    } vec_t;

    vec_t vecs[10];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name, input logic [15:0] act);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got %h, scoreboard empty", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) $display("FAIL %s: got %h expected %h", name, act, e);
            else passes++;
        end
    endtask

    task automatic wait_frame1();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame1 !== 1'b1 && n < 100);
        if (frame1 !== 1'b1) begin
            checks++;
            $display("FAIL frame1_timeout: got no pulse, expected one within 100 clk");
        end
    endtask

    task automatic wait_frame2();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame2 !== 1'b1 && n < 100);
        if (frame2 !== 1'b1) begin
            checks++;
            $display("FAIL frame2_timeout: got no pulse, expected one within 100 clk");
        end
    endtask

    // Measure clocks between consecutive frame pulses of instance 1 or 2.
    task automatic frame_period(input int which, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (((which == 1) ? frame1 : frame2) !== 1'b1 && cnt < 100);
    endtask

    initial begin
        int per;
        logic [7:0] one;
        logic [63:0] t6_seg;

        vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {8'h06, 8'h5B, 8'h77, 8'h71}};
        vecs[1] = '{16'h0005, 4'b0100, 4'b0000, 1'b1, {8'h00, 8'h80, 8'h00, 8'h6D}};
        vecs[2] = '{16'h0000, 4'b0001, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'hBF}};
        vecs[3] = '{16'h0102, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h06, 8'h3F, 8'h5B}};
        vecs[4] = '{16'h8E3C, 4'b1010, 4'b0000, 1'b0, {8'hFF, 8'h79, 8'hCF, 8'h39}};
        vecs[5] = '{16'h4567, 4'b0000, 4'b0000, 1'b1, {8'h66, 8'h6D, 8'h7D, 8'h07}};
        vecs[6] = '{16'h09D0, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h6F, 8'h5E, 8'h3F}};
        // Blink phase is 0 for digits 0,1 and 1 for digits 2,3 of every frame.
        vecs[7] = '{16'h1234, 4'b1111, 4'b1111, 1'b0, {8'h00, 8'h00, 8'hCF, 8'hE6}};
        vecs[8] = '{16'h1234, 4'b0000, 4'b0010, 1'b0, {8'h06, 8'h5B, 8'h4F, 8'h66}};
        vecs[9] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'h3F}};

        t6_seg = 64'h7F6F777C395E7971;   // digit7..digit0 active-high for 89ABCDEF

        reset = 1'b1;
        di1 = 16'h12AF; dp1 = '0; bl1 = '0; lzb1 = 1'b0;
        di2 = 32'h89ABCDEF; dp2 = '0; bl2 = '0; lzb2 = 1'b0;

        // reset state
        step(2);
        push(16'h0000); check_out("reset_out1", {8'h00, 4'h0, an1, seg1});
        push(16'h0000); check_out("reset_frame1", {15'h0, frame1});
        push(16'h0000); check_out("reset_frame2", {15'h0, frame2});
        push(16'hFFFF); check_out("reset_out2", {an2, seg2});

        // release: blank for one clk, digit 0 two clk later
        reset = 1'b0;
        push(16'h0000);
        push({8'h00, 4'b0001, 8'h71});
        step(1); check_out("release_blank", {8'h00, 4'h0, an1, seg1});
        step(1); check_out("release_digit0", {8'h00, 4'h0, an1, seg1});

        // table-driven frames
        for (int v = 0; v < 10; v++) begin
            wait_frame1();
            di1 = vecs[v].di; dp1 = vecs[v].dp; bl1 = vecs[v].bl; lzb1 = vecs[v].lzb;
            for (int k = 0; k < 4; k++) begin
                one = 8'h01 << k;
                push({8'h00, one[3:0], vecs[v].exp[8*k +: 8]});
                push({8'h00, one[3:0], vecs[v].exp[8*k +: 8]});
            end
            wait_frame1();
            for (int k = 0; k < 4; k++) begin
                step(1); check_out($sformatf("vec%0d_d%0d_first", v, k), {8'h00, 4'h0, an1, seg1});
                step(3); check_out($sformatf("vec%0d_d%0d_last", v, k), {8'h00, 4'h0, an1, seg1});
            end
        end

        // frame period
        wait_frame1();
        frame_period(1, per);
        push(16'd16); check_out("frame1_period", per[15:0]);

        // tear-free: change inputs while digit 1 is on display
        wait_frame1();
        di1 = 16'h1111; dp1 = '0; bl1 = '0; lzb1 = 1'b0;
        wait_frame1();
        push({8'h00, 4'b0001, 8'h06});
        push({8'h00, 4'b0010, 8'h06});
        push({8'h00, 4'b0010, 8'h06});
        push({8'h00, 4'b0100, 8'h06});
        push({8'h00, 4'b1000, 8'h06});
        push({8'h00, 4'b0001, 8'h5B});
        step(1); check_out("tear_d0", {8'h00, 4'h0, an1, seg1});
        step(4); check_out("tear_d1_before", {8'h00, 4'h0, an1, seg1});
        di1 = 16'h2222;
        step(3); check_out("tear_d1_after", {8'h00, 4'h0, an1, seg1});
        step(1); check_out("tear_d2", {8'h00, 4'h0, an1, seg1});
        step(4); check_out("tear_d3", {8'h00, 4'h0, an1, seg1});
        step(4); check_out("tear_next_d0", {8'h00, 4'h0, an1, seg1});

        // reset in the middle of digit 2
        wait_frame1();
        step(9);
        push({8'h00, 4'b0100, 8'h5B});
        check_out("pre_reset_d2", {8'h00, 4'h0, an1, seg1});
        #1 reset = 1'b1;
        #1;
        push(16'h0000); check_out("async_reset_out", {8'h00, 4'h0, an1, seg1});
        push(16'hFFFF); check_out("async_reset_out2", {an2, seg2});
        repeat (3) @(posedge clk);
        @(negedge clk);
        push(16'h0000); check_out("held_reset_out", {7'h00, frame1, 4'h0, an1, seg1});
        di1 = 16'h4567;
        reset = 1'b0;
        push(16'h0000);
        push({8'h00, 4'b0001, 8'h07});
        step(1); check_out("restart_blank", {8'h00, 4'h0, an1, seg1});
        step(1); check_out("restart_digit0", {8'h00, 4'h0, an1, seg1});

        // 8-digit active-low instance
        wait_frame2();
        frame_period(2, per);
        push(16'd16); check_out("frame2_period", per[15:0]);
        for (int k = 0; k < 8; k++) begin
            one = 8'h01 << k;
            push({~one, ~t6_seg[8*k +: 8]});
            push({~one, ~t6_seg[8*k +: 8]});
        end
        for (int k = 0; k < 8; k++) begin
            step(1); check_out($sformatf("t6_d%0d_first", k), {an2, seg2});
            step(1); check_out($sformatf("t6_d%0d_last", k), {an2, seg2});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
